// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Parametrised VGA raster timing generator and pixel output
//               stage. An integer divider derives a one-clk pixel strobe from
//               clk. Raster counters request pixels one pixel period ahead,
//               and a registered output stage drives blank-gated colour,
//               syncs, active and frame_start, all mutually aligned.
//
// Ports       : clk         in   system clock
//               reset_n     in   synchronous active-low reset
//               enable      in   raster run; low holds raster at (0,0), blanked
//               rgb_in      in   colour of pixel at (req_x,req_y), sampled on
//                                pixel_tick
//               pixel_tick  out  one-clk pixel strobe
//               req_x/req_y out  raster position currently requested
//               req_valid   out  requested position lies in the visible area
//               hsync/vsync out  registered sync outputs
//               rgb         out  registered colour, 0 outside visible area
//               active      out  registered, high while rgb is a visible pixel
//               frame_start out  one-clk pulse with pixel (0,0) on rgb
//
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int   CLK_DIV   = 4,
    parameter int   H_VISIBLE = 640,
    parameter int   H_FRONT   = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BACK    = 48,
    parameter int   V_VISIBLE = 480,
    parameter int   V_FRONT   = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BACK    = 33,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0,
    parameter int   COLOR_W   = 8,
    parameter int   CNT_W     = 10
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic [COLOR_W-1:0] rgb_in,
    output logic               pixel_tick,
    output logic [CNT_W-1:0]   req_x,
    output logic [CNT_W-1:0]   req_y,
    output logic               req_valid,
    output logic               hsync,
    output logic               vsync,
    output logic [COLOR_W-1:0] rgb,
    output logic               active,
    output logic               frame_start
);

    localparam int c_H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int c_V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // A one-bit divider is kept for CLK_DIV == 1; it simply stays at 0.
    localparam int c_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [c_DIV_W-1:0] c_DIV_MAX  = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_ZERO = '0;
    localparam logic [c_DIV_W-1:0] c_DIV_ONE  = c_DIV_W'(1);

    localparam logic [CNT_W-1:0] c_CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_H_LAST   = CNT_W'(c_H_TOTAL - 1);
    localparam logic [CNT_W-1:0] c_V_LAST   = CNT_W'(c_V_TOTAL - 1);
    localparam logic [CNT_W-1:0] c_H_VIS    = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] c_V_VIS    = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] c_HS_START = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] c_HS_END   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] c_VS_START = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] c_VS_END   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

    localparam logic [COLOR_W-1:0] c_BLACK = '0;

    logic [c_DIV_W-1:0] r_div;
    logic [CNT_W-1:0]   r_cx;
    logic [CNT_W-1:0]   r_cy;
    logic               r_hsync;
    logic               r_vsync;
    logic [COLOR_W-1:0] r_rgb;
    logic               r_active;
    logic               r_frame_start;

    logic w_tick;
    logic w_req_valid;
    logic w_hs_window;
    logic w_vs_window;
    logic w_line_end;
    logic w_frame_end;

    // The strobe is gated by reset_n and enable so that it drops in the very
    // cycle either of them deasserts, not one cycle later.
    assign w_tick      = enable & reset_n & (r_div == c_DIV_MAX);
    assign w_req_valid = (r_cx < c_H_VIS) & (r_cy < c_V_VIS);
    assign w_hs_window = (r_cx >= c_HS_START) & (r_cx < c_HS_END);
    assign w_vs_window = (r_cy >= c_VS_START) & (r_cy < c_VS_END);
    assign w_line_end  = (r_cx == c_H_LAST);
    assign w_frame_end = (r_cy == c_V_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_div         <= c_DIV_ZERO;
            r_cx          <= c_CNT_ZERO;
            r_cy          <= c_CNT_ZERO;
            r_hsync       <= ~HSYNC_POL;
            r_vsync       <= ~VSYNC_POL;
            r_rgb         <= c_BLACK;
            r_active      <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (!enable) begin
            // Abort the frame outright; restart is always from (0,0) with a
            // fresh divider phase.
            r_div         <= c_DIV_ZERO;
            r_cx          <= c_CNT_ZERO;
            r_cy          <= c_CNT_ZERO;
            r_hsync       <= ~HSYNC_POL;
            r_vsync       <= ~VSYNC_POL;
            r_rgb         <= c_BLACK;
            r_active      <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_div         <= (r_div == c_DIV_MAX) ? c_DIV_ZERO : r_div + c_DIV_ONE;
            r_frame_start <= w_tick & (r_cx == c_CNT_ZERO) & (r_cy == c_CNT_ZERO);

            if (w_tick) begin
                // Output stage captures the position being requested now, so
                // every output lags req_* by exactly one pixel period.
                r_hsync  <= w_hs_window ? HSYNC_POL : ~HSYNC_POL;
                r_vsync  <= w_vs_window ? VSYNC_POL : ~VSYNC_POL;
                r_active <= w_req_valid;
                r_rgb    <= w_req_valid ? rgb_in : c_BLACK;

                if (w_line_end) begin
                    r_cx <= c_CNT_ZERO;
                    r_cy <= w_frame_end ? c_CNT_ZERO : r_cy + c_CNT_ONE;
                end else begin
                    r_cx <= r_cx + c_CNT_ONE;
                end
            end
        end
    end

    assign pixel_tick  = w_tick;
    assign req_x       = r_cx;
    assign req_y       = r_cy;
    assign req_valid   = w_req_valid;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign rgb         = r_rgb;
    assign active      = r_active;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Self-checking bench for vga_timing_gen. Instance A uses the
//               default 640x480 timing with rgb_in = req_x[7:0]; instance B
//               uses a tiny CLK_DIV=1 raster with positive syncs and a
//               constant 0xFF colour. Expected values are derived from cycle
//               arithmetic and queued with their due cycle, then compared when
//               that cycle is reached.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance A: default timing ----------------
    logic       a_reset_n, a_enable;
    logic [7:0] a_rgb_in;
    logic       a_pixel_tick, a_req_valid, a_hsync, a_vsync, a_active, a_frame_start;
    logic [9:0] a_req_x, a_req_y;
    logic [7:0] a_rgb;

    assign a_rgb_in = a_req_x[7:0];

    vga_timing_gen u_dut_a (
        .clk         (clk),
        .reset_n     (a_reset_n),
        .enable      (a_enable),
        .rgb_in      (a_rgb_in),
        .pixel_tick  (a_pixel_tick),
        .req_x       (a_req_x),
        .req_y       (a_req_y),
        .req_valid   (a_req_valid),
        .hsync       (a_hsync),
        .vsync       (a_vsync),
        .rgb         (a_rgb),
        .active      (a_active),
        .frame_start (a_frame_start)
    );

    // ---------------- instance B: tiny raster, CLK_DIV=1 ----------------
    logic       b_reset_n, b_enable;
    logic [7:0] b_rgb_in;
    logic       b_pixel_tick, b_req_valid, b_hsync, b_vsync, b_active, b_frame_start;
    logic [3:0] b_req_x, b_req_y;
    logic [7:0] b_rgb;

    assign b_rgb_in = 8'hFF;

    vga_timing_gen #(
        .CLK_DIV   (1),
        .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (2), .H_BACK (2),
        .V_VISIBLE (4), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
        .HSYNC_POL (1'b1), .VSYNC_POL (1'b1),
        .COLOR_W   (8),
        .CNT_W     (4)
    ) u_dut_b (
        .clk         (clk),
        .reset_n     (b_reset_n),
        .enable      (b_enable),
        .rgb_in      (b_rgb_in),
        .pixel_tick  (b_pixel_tick),
        .req_x       (b_req_x),
        .req_y       (b_req_y),
        .req_valid   (b_req_valid),
        .hsync       (b_hsync),
        .vsync       (b_vsync),
        .rgb         (b_rgb),
        .active      (b_active),
        .frame_start (b_frame_start)
    );

    // Signal ids; B ids are A ids + 10.
    localparam int S_TICK = 0, S_RX = 1, S_RY = 2, S_RV = 3, S_HS = 4;
    localparam int S_VS = 5, S_RGB = 6, S_ACT = 7, S_FS = 8;
    localparam int A = 0, B = 10;

    typedef struct {
        int    cyc;
        int    sig;
        int    exp;
        string tag;
    } item_t;

    item_t q[$];
    int    now    = 0;
    int    checks = 0;
    int    errors = 0;

    function automatic logic [31:0] obs(input int sig);
        logic [31:0] v;
        v = '0;
        case (sig)
            A + S_TICK: v = 32'(a_pixel_tick);
            A + S_RX:   v = 32'(a_req_x);
            A + S_RY:   v = 32'(a_req_y);
            A + S_RV:   v = 32'(a_req_valid);
            A + S_HS:   v = 32'(a_hsync);
            A + S_VS:   v = 32'(a_vsync);
            A + S_RGB:  v = 32'(a_rgb);
            A + S_ACT:  v = 32'(a_active);
            A + S_FS:   v = 32'(a_frame_start);
            B + S_TICK: v = 32'(b_pixel_tick);
            B + S_RX:   v = 32'(b_req_x);
            B + S_RY:   v = 32'(b_req_y);
            B + S_RV:   v = 32'(b_req_valid);
            B + S_HS:   v = 32'(b_hsync);
            B + S_VS:   v = 32'(b_vsync);
            B + S_RGB:  v = 32'(b_rgb);
            B + S_ACT:  v = 32'(b_active);
            B + S_FS:   v = 32'(b_frame_start);
            default:    v = 32'hDEAD_BEEF;
        endcase
        return v;
    endfunction

    task automatic expect_at(input int c, input int sig, input int e, input string tag);
        item_t it;
        it.cyc = c;
        it.sig = sig;
        it.exp = e;
        it.tag = tag;
        q.push_back(it);
    endtask

    task automatic check_due();
        logic [31:0] o;
        for (int i = 0; i < q.size(); ) begin
            if (q[i].cyc == now) begin
                o = obs(q[i].sig);
                checks++;
                assert (o === 32'(q[i].exp)) else begin
                    errors++;
                    $error("FAIL %s cycle=%0d observed=%0d expected=%0d",
                           q[i].tag, now, o, q[i].exp);
                end
                q.delete(i);
            end else begin
                i++;
            end
        end
    endtask

    // Advance to cycle c, sampling at negedge+1 of every cycle on the way.
    task automatic run_to(input int c);
        while (now < c) begin
            @(negedge clk);
            now++;
            #1;
            check_due();
        end
    endtask

    // Every queued expectation must have been compared before a restart.
    task automatic end_scenario(input string tag);
        checks++;
        assert (q.size() == 0) else begin
            errors++;
            $error("FAIL %s_leftover observed=%0d expected=0", tag, q.size());
        end
        q.delete();
    endtask

    task automatic push_reset_values(input int c, input int base, input int inact);
        expect_at(c, base + S_TICK, 0, "rst_tick");
        expect_at(c, base + S_RX,   0, "rst_req_x");
        expect_at(c, base + S_RY,   0, "rst_req_y");
        expect_at(c, base + S_RV,   1, "rst_req_valid");
        expect_at(c, base + S_HS,   inact, "rst_hsync");
        expect_at(c, base + S_VS,   inact, "rst_vsync");
        expect_at(c, base + S_RGB,  0, "rst_rgb");
        expect_at(c, base + S_ACT,  0, "rst_active");
        expect_at(c, base + S_FS,   0, "rst_frame_start");
    endtask

    // Start-of-frame timing of A: tick k at 4k+3, outputs for k at 4(k+1).
    task automatic push_line0();
        expect_at(2,    A + S_TICK, 0, "a_tick_c2");
        expect_at(3,    A + S_TICK, 1, "a_tick_c3");
        expect_at(3,    A + S_FS,   0, "a_fs_c3");
        expect_at(4,    A + S_FS,   1, "a_fs_c4");
        expect_at(5,    A + S_FS,   0, "a_fs_c5");
        expect_at(4,    A + S_RGB,  0, "a_rgb_c4");
        expect_at(4,    A + S_ACT,  1, "a_active_c4");
        expect_at(8,    A + S_RGB,  1, "a_rgb_c8");
        expect_at(2627, A + S_HS,   1, "a_hsync_c2627");
        expect_at(2628, A + S_HS,   0, "a_hsync_fall");
        expect_at(3011, A + S_HS,   0, "a_hsync_c3011");
        expect_at(3012, A + S_HS,   1, "a_hsync_rise");
    endtask

    initial begin
        a_reset_n = 1'b0; a_enable = 1'b1;
        b_reset_n = 1'b0; b_enable = 1'b1;
        now = 0;

        // ---- reset values of both instances ----
        push_reset_values(3, A, 1);
        push_reset_values(3, B, 0);
        run_to(3);
        end_scenario("reset");

        // ---- A: first line, rgb_in = req_x[7:0] ----
        a_reset_n = 1'b1;
        now = 0;
        push_line0();
        expect_at(3,    A + S_RX,  0,   "a_req_x_c3");
        expect_at(4,    A + S_RX,  1,   "a_req_x_c4");
        expect_at(404,  A + S_RGB, 100, "a_rgb_x100");
        expect_at(2559, A + S_RV,  1,   "a_req_valid_x639");
        expect_at(2563, A + S_RGB, 127, "a_rgb_x639");
        expect_at(2563, A + S_ACT, 1,   "a_active_x639");
        expect_at(2564, A + S_RGB, 0,   "a_rgb_x640");
        expect_at(2564, A + S_ACT, 0,   "a_active_x640");
        expect_at(2564, A + S_RV,  0,   "a_req_valid_x641");
        expect_at(3199, A + S_RY,  0,   "a_req_y_c3199");
        expect_at(3200, A + S_RY,  1,   "a_req_y_c3200");
        expect_at(3200, A + S_VS,  1,   "a_vsync_line0");
        expect_at(3204, A + S_FS,  0,   "a_fs_line1");
        run_to(3300);
        end_scenario("a_line0");

        // ---- A: enable dropped mid-line at x=300 ----
        a_reset_n = 1'b0;
        run_to(now + 2);
        a_reset_n = 1'b1;
        now = 0;
        expect_at(1200, A + S_RX, 300, "a_req_x_300");
        expect_at(1201, A + S_RX, 300, "a_req_x_300b");
        run_to(1201);
        a_enable = 1'b0;
        expect_at(1202, A + S_RX,   0, "dis_req_x");
        expect_at(1202, A + S_RY,   0, "dis_req_y");
        expect_at(1202, A + S_RGB,  0, "dis_rgb");
        expect_at(1202, A + S_ACT,  0, "dis_active");
        expect_at(1202, A + S_HS,   1, "dis_hsync");
        expect_at(1202, A + S_VS,   1, "dis_vsync");
        expect_at(1202, A + S_TICK, 0, "dis_tick");
        expect_at(1202, A + S_FS,   0, "dis_fs");
        expect_at(1208, A + S_RX,   0, "dis_hold_req_x");
        expect_at(1208, A + S_TICK, 0, "dis_hold_tick");
        run_to(1209);
        a_enable = 1'b1;
        expect_at(1211, A + S_TICK, 0, "ren_tick_c2");
        expect_at(1212, A + S_TICK, 1, "ren_tick_c3");
        expect_at(1212, A + S_FS,   0, "ren_fs_early");
        expect_at(1213, A + S_FS,   1, "ren_fs");
        expect_at(1213, A + S_RGB,  0, "ren_rgb_x0");
        expect_at(1213, A + S_ACT,  1, "ren_active");
        expect_at(1213, A + S_RX,   1, "ren_req_x");
        expect_at(1217, A + S_RGB,  1, "ren_rgb_x1");
        run_to(1220);
        end_scenario("a_enable");

        // ---- A: reset asserted mid-hsync, then first-line timing again ----
        a_reset_n = 1'b0;
        run_to(now + 2);
        a_reset_n = 1'b1;
        now = 0;
        expect_at(2700, A + S_HS, 0, "midsync_hsync");
        run_to(2700);
        a_reset_n = 1'b0;
        push_reset_values(2701, A, 1);
        run_to(2703);
        a_reset_n = 1'b1;
        now = 0;
        push_line0();
        run_to(3100);
        end_scenario("a_reset");

        // ---- B: two full frames, then enable dropped during both syncs ----
        b_reset_n = 1'b1;
        now = 0;
        for (int c = 1; c <= 277; c++) begin
            int p, x, y, act;
            p   = (c - 1) % 98;
            x   = p % 14;
            y   = p / 14;
            act = (x < 8 && y < 4) ? 1 : 0;
            expect_at(c, B + S_TICK, 1, "b_tick");
            expect_at(c, B + S_FS,   (p == 0) ? 1 : 0, "b_fs");
            expect_at(c, B + S_ACT,  act, "b_active");
            expect_at(c, B + S_RGB,  act ? 255 : 0, "b_rgb");
            expect_at(c, B + S_HS,   (x >= 10 && x <= 11) ? 1 : 0, "b_hsync");
            expect_at(c, B + S_VS,   (y == 5) ? 1 : 0, "b_vsync");
            expect_at(c, B + S_RX,   (c % 98) % 14, "b_req_x");
            expect_at(c, B + S_RY,   (c % 98) / 14, "b_req_y");
        end
        run_to(277);
        b_enable = 1'b0;
        expect_at(278, B + S_HS,   0, "b_dis_hsync");
        expect_at(278, B + S_VS,   0, "b_dis_vsync");
        expect_at(278, B + S_RGB,  0, "b_dis_rgb");
        expect_at(278, B + S_ACT,  0, "b_dis_active");
        expect_at(278, B + S_RX,   0, "b_dis_req_x");
        expect_at(278, B + S_RY,   0, "b_dis_req_y");
        expect_at(278, B + S_TICK, 0, "b_dis_tick");
        expect_at(278, B + S_FS,   0, "b_dis_fs");
        run_to(279);
        b_enable = 1'b1;
        expect_at(280, B + S_FS,   1,   "b_ren_fs");
        expect_at(280, B + S_ACT,  1,   "b_ren_active");
        expect_at(280, B + S_RGB,  255, "b_ren_rgb");
        expect_at(280, B + S_RX,   1,   "b_ren_req_x");
        expect_at(280, B + S_TICK, 1,   "b_ren_tick");
        run_to(285);
        end_scenario("b_frames");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
